// File: rtl/scan_gen_2d.sv
// scan_gen_2d: walks a strided (x, y) window in raster or serpentine order on a valid/ready stream.
// Latency: first beat 1 cycle after an accepted start, then up to one beat per cycle with no bubbles.
// Backpressure: a beat is held stable while out_ready is low. SCAN_REPEAT_EN makes frames loop until abort.
module scan_gen_2d #(
   parameter int X_BITS = 10,
   parameter int Y_BITS = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic              mode,
   input  logic [X_BITS-1:0] x_start,
   input  logic [X_BITS-1:0] x_end,
   input  logic [Y_BITS-1:0] y_start,
   input  logic [Y_BITS-1:0] y_end,
   input  logic [X_BITS-1:0] x_step,
   input  logic [Y_BITS-1:0] y_step,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [X_BITS-1:0] out_x,
   output logic [Y_BITS-1:0] out_y,
   output logic              out_eol,
   output logic              out_eof,
   output logic              busy,
   output logic              done,
   output logic              cfg_err
);

   typedef enum logic {IDLE, SCAN} state_t;

   state_t state, state_nxt;

   logic [X_BITS-1:0] xs_q, xe_q, xst_q, x_q;
   logic [Y_BITS-1:0] ys_q, ye_q, yst_q, y_q;
   logic              mode_q, rev_q;

   logic              cfg_ok, xfer, line_end, frame_end;
   logic [X_BITS:0]   x_span;
   logic [Y_BITS:0]   y_span;

   assign cfg_ok = (x_start <= x_end) && (y_start <= y_end);
   assign xfer   = (state == SCAN) && out_ready;

   // Remaining distance to the row boundary in the current direction, one bit wider so it never wraps.
   assign x_span    = rev_q ? ({1'b0, x_q} - {1'b0, xs_q}) : ({1'b0, xe_q} - {1'b0, x_q});
   assign y_span    = {1'b0, ye_q} - {1'b0, y_q};
   assign line_end  = x_span < {1'b0, xst_q};
   assign frame_end = line_end && (y_span < {1'b0, yst_q});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start && cfg_ok) state_nxt = SCAN;
         SCAN: begin
            if (abort)
               state_nxt = IDLE;
            else if (xfer && frame_end) begin
`ifdef SCAN_REPEAT_EN
               state_nxt = SCAN;
`else
               state_nxt = IDLE;
`endif
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      out_valid = (state == SCAN);
      busy      = (state == SCAN);
      out_eol   = out_valid && line_end;
      out_eof   = out_valid && frame_end;
      out_x     = x_q;
      out_y     = y_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         xs_q    <= '0;
         xe_q    <= '0;
         xst_q   <= X_BITS'(1);
         ys_q    <= '0;
         ye_q    <= '0;
         yst_q   <= Y_BITS'(1);
         mode_q  <= 1'b0;
         rev_q   <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
         done    <= 1'b0;
         cfg_err <= 1'b0;
      end else begin
         done    <= 1'b0;
         cfg_err <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (cfg_ok) begin
                     xs_q   <= x_start;
                     xe_q   <= x_end;
                     ys_q   <= y_start;
                     ye_q   <= y_end;
                     xst_q  <= (x_step == '0) ? X_BITS'(1) : x_step;
                     yst_q  <= (y_step == '0) ? Y_BITS'(1) : y_step;
                     mode_q <= mode;
                     rev_q  <= 1'b0;
                     x_q    <= x_start;
                     y_q    <= y_start;
                  end else begin
                     cfg_err <= 1'b1;
                  end
               end
            end
            SCAN: begin
               if (!abort && xfer) begin
                  if (frame_end) begin
                     done <= 1'b1;
`ifdef SCAN_REPEAT_EN
                     x_q   <= xs_q;
                     y_q   <= ys_q;
                     rev_q <= 1'b0;
`endif
                  end else if (line_end) begin
                     y_q <= y_q + yst_q;
                     // Serpentine keeps the column and turns around; raster rewinds to the left edge.
                     if (mode_q) rev_q <= ~rev_q;
                     else        x_q   <= xs_q;
                  end else begin
                     x_q <= rev_q ? (x_q - xst_q) : (x_q + xst_q);
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_scan_gen_2d.sv
// Bench for scan_gen_2d: directed cases plus randomized frames checked against a list-based traversal model.
module tb_scan_gen_2d;

   localparam int XB = 10;
   localparam int YB = 10;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0, abort = 1'b0, mode = 1'b0, out_ready = 1'b0;
   logic [XB-1:0] x_start = '0, x_end = '0, x_step = '0;
   logic [YB-1:0] y_start = '0, y_end = '0, y_step = '0;
   logic          out_valid, out_eol, out_eof, busy, done, cfg_err;
   logic [XB-1:0] out_x;
   logic [YB-1:0] out_y;

   int checks = 0;
   int errors = 0;

   typedef struct {int x; int y; bit eol; bit eof;} beat_t;
   beat_t exp_q[$];

   scan_gen_2d #(.X_BITS(XB), .Y_BITS(YB)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
      .x_start(x_start), .x_end(x_end), .y_start(y_start), .y_end(y_end),
      .x_step(x_step), .y_step(y_step),
      .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
      .out_eol(out_eol), .out_eof(out_eof), .busy(busy), .done(done), .cfg_err(cfg_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Expected frame: list of columns and rows, odd rows reversed in serpentine mode.
   task automatic build(input int xs, xe, ys, ye, xst, yst, input bit m);
      int cols[$];
      int rows[$];
      int sx = (xst == 0) ? 1 : xst;
      int sy = (yst == 0) ? 1 : yst;
      exp_q.delete();
      for (int c = xs; c <= xe; c += sx) cols.push_back(c);
      for (int r = ys; r <= ye; r += sy) rows.push_back(r);
      for (int r = 0; r < rows.size(); r++)
         for (int k = 0; k < cols.size(); k++) begin
            beat_t b;
            b.x   = (m && (r % 2 == 1)) ? cols[cols.size()-1-k] : cols[k];
            b.y   = rows[r];
            b.eol = (k == cols.size()-1);
            b.eof = b.eol && (r == rows.size()-1);
            exp_q.push_back(b);
         end
   endtask

   task automatic kick(input int xs, xe, ys, ye, xst, yst, input bit m);
      @(negedge clk);
      x_start = XB'(xs); x_end = XB'(xe); x_step = XB'(xst);
      y_start = YB'(ys); y_end = YB'(ye); y_step = YB'(yst);
      mode = m; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      // Scramble config inputs: the frame must run on the captured copy.
      x_start = XB'($urandom); x_end = XB'($urandom); x_step = XB'($urandom);
      y_start = YB'($urandom); y_end = YB'($urandom); y_step = YB'($urandom);
      mode = 1'($urandom);
   endtask

   // rmode: 0 always ready, 1 pattern 1,0,0 repeating, 2 random
   task automatic run_frame(input int xs, xe, ys, ye, xst, yst, input bit m, input int rmode);
      int cyc = 0;
      int nx = 0;
      int ph = 0;
      int total;
      beat_t b;
      build(xs, xe, ys, ye, xst, yst, m);
      total = exp_q.size();
      kick(xs, xe, ys, ye, xst, yst, m);
      while (exp_q.size() > 0 && cyc < 4000) begin
         if (rmode == 0)      out_ready = 1'b1;
         else if (rmode == 1) out_ready = (ph % 3 == 0);
         else                 out_ready = 1'($urandom_range(0, 1));
         ph++;
         chk("valid_in_frame", out_valid, 1);
         if (out_valid !== 1'b1) break;
         b = exp_q[0];
         chk("out_x", out_x, b.x);
         chk("out_y", out_y, b.y);
         chk("out_eol", out_eol, b.eol);
         chk("out_eof", out_eof, b.eof);
         chk("busy_in_frame", busy, 1);
         chk("done_in_frame", done, 0);
         if (out_ready) begin
            void'(exp_q.pop_front());
            nx++;
         end
         @(negedge clk);
         cyc++;
      end
      chk("transfers", nx, total);
      out_ready = 1'b0;
      chk("done_pulse", done, 1);
`ifdef SCAN_REPEAT_EN
      chk("repeat_valid", out_valid, 1);
      chk("repeat_x", out_x, xs);
      chk("repeat_y", out_y, ys);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("repeat_abort_valid", out_valid, 0);
`else
      chk("end_valid", out_valid, 0);
      chk("end_busy", busy, 0);
      chk("end_eol", out_eol, 0);
      chk("end_eof", out_eof, 0);
      @(negedge clk);
      chk("done_once", done, 0);
`endif
   endtask

   initial begin
      int xs, xe, ys, ye;

      // Reset state
      #12;
      chk("rst_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_cfg_err", cfg_err, 0);
      chk("rst_eol", out_eol, 0);
      chk("rst_eof", out_eof, 0);
      chk("rst_x", out_x, 0);
      chk("rst_y", out_y, 0);
      @(negedge clk);
      rst = 1'b0;

      // Directed frames from the plan
      run_frame(2, 4, 1, 2, 1, 1, 1'b0, 0);
      run_frame(0, 3, 0, 2, 2, 1, 1'b1, 0);
      run_frame(2, 4, 1, 2, 1, 1, 1'b0, 1);

      // Bad configs on each axis
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         x_start = (i == 0) ? XB'(5) : XB'(0); x_end = (i == 0) ? XB'(3) : XB'(3);
         y_start = (i == 0) ? YB'(0) : YB'(4); y_end = YB'(2);
         x_step = XB'(1); y_step = YB'(1); start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         chk("cfg_err_pulse", cfg_err, 1);
         chk("cfg_err_busy", busy, 0);
         chk("cfg_err_valid", out_valid, 0);
         @(negedge clk);
         chk("cfg_err_once", cfg_err, 0);
         chk("cfg_err_idle", out_valid, 0);
      end
      run_frame(0, 1, 0, 0, 0, 0, 1'b0, 0);

      // Single-point window and max-edge windows (no wrap past x_end)
      run_frame(7, 7, 9, 9, 3, 3, 1'b1, 0);
      run_frame(1020, 1023, 1021, 1023, 2, 2, 1'b0, 2);
      run_frame(1000, 1023, 1023, 1023, 1023, 0, 1'b1, 2);

      // Abort on 3rd beat of a 3x3 raster
      build(0, 2, 0, 2, 1, 1, 1'b0);
      out_ready = 1'b1;
      kick(0, 2, 0, 2, 1, 1, 1'b0);
      for (int i = 0; i < 2; i++) begin
         chk("abort_pre_x", out_x, exp_q[i].x);
         @(negedge clk);
      end
      chk("abort_third_x", out_x, 2);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      out_ready = 1'b0;
      chk("abort_valid", out_valid, 0);
      chk("abort_busy", busy, 0);
      chk("abort_no_done", done, 0);
      @(negedge clk);
      chk("abort_no_done2", done, 0);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_idle_noop", busy, 0);
      run_frame(0, 2, 0, 2, 1, 1, 1'b0, 0);

      // Start while scanning is ignored
      kick(0, 3, 0, 0, 1, 1, 1'b0);
      out_ready = 1'b1;
      @(negedge clk);
      x_start = XB'(9); x_end = XB'(9); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("start_ignored_x", out_x, 2);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      out_ready = 1'b0;

      // Async reset mid-frame
      kick(3, 9, 2, 5, 1, 1, 1'b0);
      out_ready = 1'b1;
      @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_valid", out_valid, 0);
      chk("arst_busy", busy, 0);
      chk("arst_x", out_x, 0);
      chk("arst_y", out_y, 0);
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      chk("arst_hold_idle", out_valid, 0);

      // Randomized frames
      for (int n = 0; n < 25; n++) begin
         xs = $urandom_range(0, 1023);
         xe = xs + $urandom_range(0, 12);
         if (xe > 1023 || n % 5 == 0) xe = 1023;
         ys = $urandom_range(0, 1023);
         ye = ys + $urandom_range(0, 4);
         if (ye > 1023) ye = 1023;
         run_frame(xs, xe, ys, ye, $urandom_range(0, 5), $urandom_range(0, 3),
                   1'($urandom_range(0, 1)), 2);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
